rf_wb_arbiter: RTL

Shares the register file's single write port between two writeback sources: source 0 is the ALU/execute path and source 1 is the memory/load path. Each source has a one-entry holding buffer behind a valid/ready handshake. A round-robin arbiter drains the buffers into a registered write port that drives write-enable, write-register-number and write-data on the register file. It sits between the execute/memory stages and the register file's writeback inputs, and it is the only writer of those inputs.

---
 rtl/rf_wb_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: two one-entry source buffers drained round-robin
// into a single registered write port (source 0 = ALU, source 1 = load).

module rf_wb_buf #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              grant,
  output logic              ready,
  output logic              full,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] data
);
  // A granted buffer drains this edge, so it may refill on the same edge.
  assign ready = !full || grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (valid && ready) begin
      full <= 1'b1;
      rd   <= rd_in;
      data <= data_in;
    end else if (grant) begin
      full <= 1'b0;
    end
  end
endmodule

module rf_wb_arbiter #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s0_valid,
  input  logic [REG_W-1:0]  s0_reg,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [REG_W-1:0]  s1_reg,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic              wb_write_the_register,
  output logic [REG_W-1:0]  wb_write_reg_num,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_grant_src,
  output logic              idle
);
  localparam int NSRC = 2;

  logic [NSRC-1:0]             valid, ready, full, grant;
  logic [NSRC-1:0][REG_W-1:0]  in_rd, buf_rd;
  logic [NSRC-1:0][DATA_W-1:0] in_data, buf_data;
  logic                        ptr, gnt_src, gnt_any;

  assign valid   = {s1_valid, s0_valid};
  assign in_rd   = {s1_reg, s0_reg};
  assign in_data = {s1_data, s0_data};
  assign s0_ready = ready[0];
  assign s1_ready = ready[1];

  generate
    for (genvar i = 0; i < NSRC; i++) begin : g_src
      rf_wb_buf #(.DATA_W(DATA_W), .REG_W(REG_W)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid[i]),
        .rd_in   (in_rd[i]),
        .data_in (in_data[i]),
        .grant   (grant[i]),
        .ready   (ready[i]),
        .full    (full[i]),
        .rd      (buf_rd[i]),
        .data    (buf_data[i])
      );
    end
  endgenerate

  // Grant depends only on flops, keeping valid->ready free of combinational paths.
  always_comb begin
    gnt_any = |full;
    gnt_src = (full == 2'b11) ? ptr : full[1];
    grant   = '0;
    if (gnt_any) grant[gnt_src] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr                   <= 1'b0;
      wb_write_the_register <= 1'b0;
      wb_write_reg_num      <= '0;
      wb_write_data         <= '0;
      wb_grant_src          <= 1'b0;
    end else if (gnt_any) begin
      ptr                   <= ~gnt_src;
      wb_write_reg_num      <= buf_rd[gnt_src];
      wb_write_data         <= buf_data[gnt_src];
      wb_grant_src          <= gnt_src;
      // x0 still takes its slot but never reaches the register file.
      wb_write_the_register <= (buf_rd[gnt_src] != '0);
    end else begin
      wb_write_the_register <= 1'b0;
    end
  end

  assign idle = !full[0] && !full[1] && !wb_write_the_register;
endmodule
